// File: rtl/fpall_pkg.sv
// rtl/fpall_pkg.sv - shared fpall types, scheduler state encoding and per-op latency lookup
package fpall_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_MUL  = 2'd1,
        OP_SQRT = 2'd2,
        OP_DIV  = 2'd3
    } fp_op_e;

    typedef enum logic {
        FP32 = 1'b0,
        FP16 = 1'b1
    } fp_fmt_e;

    typedef union packed {
        logic [31:0] f32;
        struct packed {
            logic [15:0] hi;
            logic [15:0] lo;
        } bf16;
    } fp_vec_u;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_e;

    localparam int CNT_W = 6;

    function automatic logic [CNT_W-1:0] op_latency(fp_op_e op, int lat_add, int lat_mul,
                                                    int lat_sqrt, int lat_div);
        logic [CNT_W-1:0] lat;
        case (op)
            OP_ADD:  lat = CNT_W'(lat_add);
            OP_MUL:  lat = CNT_W'(lat_mul);
            OP_SQRT: lat = CNT_W'(lat_sqrt);
            default: lat = CNT_W'(lat_div);
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/fpall_sched_if.sv
// rtl/fpall_sched_if.sv - request, datapath and response signals of the fpall issue controller
interface fpall_sched_if;
    import fpall_pkg::*;

    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    fp_op_e      req0_op;
    fp_op_e      req1_op;
    fp_fmt_e     req0_fmt;
    fp_fmt_e     req1_fmt;
    fp_vec_u     req0_a;
    fp_vec_u     req0_b;
    fp_vec_u     req1_a;
    fp_vec_u     req1_b;

    logic        dp_start;
    fp_op_e      dp_op;
    fp_fmt_e     dp_fmt;
    fp_vec_u     dp_a;
    fp_vec_u     dp_b;
    logic [31:0] dp_result;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_data;

    modport master (
        output req_valid, req0_op, req1_op, req0_fmt, req1_fmt,
               req0_a, req0_b, req1_a, req1_b, dp_result, rsp_ready,
        input  req_ready, dp_start, dp_op, dp_fmt, dp_a, dp_b,
               rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req0_op, req1_op, req0_fmt, req1_fmt,
               req0_a, req0_b, req1_a, req1_b, dp_result, rsp_ready,
        output req_ready, dp_start, dp_op, dp_fmt, dp_a, dp_b,
               rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/fpall_rr_arb2.sv
// rtl/fpall_rr_arb2.sv - two-input round-robin arbiter, history updated only on accept
module fpall_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    logic last_grant_q, last_grant_d;

    always_comb begin
        grant_o      = 2'b00;
        last_grant_d = last_grant_q;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
        if (accept_i) begin
            last_grant_d = grant_o[1];
        end
    end

    // Reset history points at requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/fpall_sched.sv
// rtl/fpall_sched.sv - two-requester issue controller for the non-pipelined fpall unit
// Optional performance counters enabled with FPALL_SCHED_PERF_EN.
module fpall_sched
    import fpall_pkg::*;
#(
    parameter int LAT_ADD  = 2,
    parameter int LAT_MUL  = 3,
    parameter int LAT_SQRT = 12,
    parameter int LAT_DIV  = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    fpall_sched_if.slave  bus
`ifdef FPALL_SCHED_PERF_EN
    ,
    output logic [31:0]   perf_ops,
    output logic [31:0]   perf_busy
`endif
);

    sched_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    fp_op_e           op_q, op_d;
    fp_fmt_e          fmt_q, fmt_d;
    fp_vec_u          a_q, a_d, b_q, b_d;
    logic             id_q, id_d;
    logic [31:0]      data_q, data_d;

    logic [1:0]       arb_req;
    logic [1:0]       grant;
    logic             accept;
    logic             sel;

    assign arb_req = (state_q == IDLE) ? bus.req_valid : 2'b00;

    fpall_rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (arb_req),
        .accept_i (accept),
        .grant_o  (grant)
    );

    // Gated by reset so req_ready reads 0 while reset is asserted, even with requests pending.
    assign bus.req_ready = rst_n ? grant : 2'b00;
    assign accept        = |bus.req_ready;
    assign sel           = grant[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        fmt_d   = fmt_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = sel ? bus.req1_op  : bus.req0_op;
                    fmt_d   = sel ? bus.req1_fmt : bus.req0_fmt;
                    a_d     = sel ? bus.req1_a   : bus.req0_a;
                    b_d     = sel ? bus.req1_b   : bus.req0_b;
                    id_d    = sel;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = op_latency(op_q, LAT_ADD, LAT_MUL, LAT_SQRT, LAT_DIV);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    data_d  = bus.dp_result;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_ADD;
            fmt_q   <= FP32;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            fmt_q   <= fmt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            data_q  <= data_d;
        end
    end

    assign bus.dp_start  = (state_q == ISSUE);
    assign bus.dp_op     = op_q;
    assign bus.dp_fmt    = fmt_q;
    assign bus.dp_a      = a_q;
    assign bus.dp_b      = b_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = data_q;

`ifdef FPALL_SCHED_PERF_EN
    logic [31:0] perf_ops_q, perf_busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops_q  <= '0;
            perf_busy_q <= '0;
        end else begin
            if (state_q == ISSUE) begin
                perf_ops_q <= perf_ops_q + 32'd1;
            end
            if (state_q != IDLE) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
        end
    end

    assign perf_ops  = perf_ops_q;
    assign perf_busy = perf_busy_q;
`endif

endmodule

// File: tb/tb_fpall_sched.sv
// tb/tb_fpall_sched.sv - self-checking bench for fpall_sched with a transaction-timing model
module tb_fpall_sched;
    import fpall_pkg::*;

    localparam int LA = 2;
    localparam int LM = 3;
    localparam int LS = 12;
    localparam int LD = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpall_sched_if bus();

`ifdef FPALL_SCHED_PERF_EN
    logic [31:0] perf_ops, perf_busy;
`endif

    fpall_sched #(.LAT_ADD(LA), .LAT_MUL(LM), .LAT_SQRT(LS), .LAT_DIV(LD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FPALL_SCHED_PERF_EN
        ,
        .perf_ops  (perf_ops),
        .perf_busy (perf_busy)
`endif
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic int lat_of(logic [1:0] op);
        case (op)
            2'd0:    return LA;
            2'd1:    return LM;
            2'd2:    return LS;
            default: return LD;
        endcase
    endfunction

    // Stand-in datapath: one known FP32 add, otherwise an easily predicted mix of the inputs.
    function automatic logic [31:0] golden(logic [1:0] op, logic fmt, logic [31:0] a, logic [31:0] b);
        if (op == 2'd0 && fmt == 1'b0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        return {a[15:0], b[15:0]} ^ {29'd0, fmt, op};
    endfunction

    // Transaction model: one op in flight, timed from its accept cycle.
    bit          m_busy = 0;
    int          m_tacc = 0;
    int          m_lat = 1;
    bit          m_last = 1;
    logic [1:0]  m_op = 0;
    logic        m_fmt = 0;
    logic [31:0] m_a = 0, m_b = 0, m_rdata = 0, m_gold = 0;
    logic        m_id = 0;

    assign bus.dp_result = (m_busy && cyc == m_tacc + 1 + m_lat) ? m_gold : (32'hBAD00000 ^ 32'(cyc));

    always @(negedge clk) begin
        logic [1:0] exp_rdy;
        logic       exp_rv;
        if (!rst_n) begin
            m_busy = 0; m_last = 1; m_op = 0; m_fmt = 0; m_a = 0; m_b = 0; m_id = 0; m_rdata = 0;
        end
        exp_rdy = 2'b00;
        if (rst_n && !m_busy) begin
            if (bus.req_valid == 2'b01) exp_rdy = 2'b01;
            else if (bus.req_valid == 2'b10) exp_rdy = 2'b10;
            else if (bus.req_valid == 2'b11) exp_rdy = m_last ? 2'b01 : 2'b10;
        end
        exp_rv = m_busy && (cyc >= m_tacc + 2 + m_lat);
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        chk("dp_start", 32'(bus.dp_start), 32'(m_busy && cyc == m_tacc + 1));
        chk("dp_op", 32'(bus.dp_op), 32'(m_op));
        chk("dp_fmt", 32'(bus.dp_fmt), 32'(m_fmt));
        chk("dp_a", bus.dp_a, m_a);
        chk("dp_b", bus.dp_b, m_b);
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
        chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
        chk("rsp_data", bus.rsp_data, m_rdata);
        if (rst_n) begin
            if (|exp_rdy) begin
                m_id   = exp_rdy[1];
                m_last = exp_rdy[1];
                m_op   = m_id ? bus.req1_op  : bus.req0_op;
                m_fmt  = m_id ? bus.req1_fmt : bus.req0_fmt;
                m_a    = m_id ? bus.req1_a   : bus.req0_a;
                m_b    = m_id ? bus.req1_b   : bus.req0_b;
                m_lat  = lat_of(m_op);
                m_gold = golden(m_op, m_fmt, m_a, m_b);
                m_tacc = cyc;
                m_busy = 1;
            end else if (m_busy && cyc == m_tacc + 1 + m_lat) begin
                m_rdata = m_gold;
            end else if (exp_rv && bus.rsp_ready) begin
                m_busy = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int idx, logic v, fp_op_e op, fp_fmt_e fmt, logic [31:0] a, logic [31:0] b);
        bus.req_valid[idx] = v;
        if (idx == 0) begin
            bus.req0_op = op; bus.req0_fmt = fmt; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_op = op; bus.req1_fmt = fmt; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    task automatic wait_accept(output int t, output logic id);
        t = -1;
        id = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (|(bus.req_ready & bus.req_valid)) begin
                t = cyc;
                id = bus.req_ready[1];
                break;
            end
        end
        checks++;
        if (t < 0) begin
            failures++;
            $display("FAIL accept_timeout cycle=%0d got=none expected=accept", cyc);
        end
        tick();
    endtask

    task automatic watch(output int ds, output int rv);
        ds = -1;
        rv = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.dp_start && ds < 0) ds = cyc;
            if (bus.rsp_valid) begin
                rv = cyc;
                break;
            end
        end
        checks++;
        if (rv < 0) begin
            failures++;
            $display("FAIL rsp_timeout cycle=%0d got=none expected=rsp_valid", cyc);
        end
    endtask

    initial begin
        int   t, t0, t1, t2, ds, rv, seen;
        logic id;
        logic [3:0] ids;
        bus.req_valid = 2'b00;
        set_req(0, 1'b0, OP_ADD, FP32, 32'h0, 32'h0);
        set_req(1, 1'b0, OP_ADD, FP32, 32'h0, 32'h0);
        bus.rsp_ready = 1'b1;
        repeat (3) tick();
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("reset_dp_a", bus.dp_a, 32'h0);
        rst_n = 1'b1;
        tick();

        // Tie every cycle: grants alternate starting with requester 0.
        set_req(0, 1'b1, OP_ADD, FP32, 32'h00000011, 32'h00000022);
        set_req(1, 1'b1, OP_MUL, FP32, 32'h00000033, 32'h00000044);
        wait_accept(t0, id); ids[0] = id;
        wait_accept(t1, id); ids[1] = id;
        wait_accept(t2, id); ids[2] = id;
        wait_accept(t, id);  ids[3] = id;
        bus.req_valid = 2'b00;
        chk("rr_grants", 32'(ids), 32'b1010);
        chk("add_spacing", 32'(t1 - t0), 32'd5);
        chk("mul_spacing", 32'(t2 - t1), 32'd6);
        watch(ds, rv);
        tick();

        // Single FP32 ADD from requester 0 (history now favours 0 again).
        set_req(0, 1'b1, OP_ADD, FP32, 32'h3F800000, 32'h40000000);
        wait_accept(t, id);
        bus.req_valid = 2'b00;
        watch(ds, rv);
        chk("add_start_lat", 32'(ds - t), 32'd1);
        chk("add_rsp_lat", 32'(rv - t), 32'd4);
        chk("add_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("add_rsp_data", bus.rsp_data, 32'h40400000);
        tick();

        // FP16 DIV from requester 1.
        set_req(1, 1'b1, OP_DIV, FP16, 32'h3F804000, 32'h40004000);
        wait_accept(t, id);
        bus.req_valid = 2'b00;
        watch(ds, rv);
        chk("div_rsp_lat", 32'(rv - t), 32'd14);
        chk("div_dp_fmt", 32'(bus.dp_fmt), 32'd1);
        chk("div_rsp_id", 32'(bus.rsp_id), 32'd1);
        chk("div_rsp_data", bus.rsp_data, 32'h40004007);
        tick();

        // Response backpressure for 5 cycles with a request waiting behind it.
        bus.rsp_ready = 1'b0;
        set_req(0, 1'b1, OP_ADD, FP32, 32'h3F800000, 32'h40000000);
        wait_accept(t, id);
        watch(ds, rv);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_data", bus.rsp_data, 32'h40400000);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        tick();
        bus.rsp_ready = 1'b1;
        wait_accept(t, id);
        chk("bp_resume", 32'(t - rv), 32'd6);
        bus.req_valid = 2'b00;
        watch(ds, rv);
        tick();

        // Reset in the middle of a SQRT.
        set_req(0, 1'b1, OP_SQRT, FP32, 32'h40800000, 32'h00000000);
        wait_accept(t, id);
        bus.req_valid = 2'b00;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_dp_op", 32'(bus.dp_op), 32'd0);
        chk("rst_dp_a", bus.dp_a, 32'h0);
        chk("rst_rsp_data", bus.rsp_data, 32'h0);
        chk("rst_dp_start", 32'(bus.dp_start), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        chk("rst_no_rsp", 32'(seen), 32'd0);
        tick();
        set_req(0, 1'b1, OP_ADD, FP32, 32'h00000055, 32'h00000066);
        set_req(1, 1'b1, OP_MUL, FP32, 32'h00000077, 32'h00000088);
        wait_accept(t, id);
        bus.req_valid = 2'b00;
        chk("rst_tie_winner", 32'(id), 32'd0);
        watch(ds, rv);
        tick();

`ifdef FPALL_SCHED_PERF_EN
        rst_n = 1'b0;
        #1;
        chk("perf_ops_reset", perf_ops, 32'd0);
        chk("perf_busy_reset", perf_busy, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        set_req(0, 1'b1, OP_MUL, FP32, 32'h00000101, 32'h00000202);
        wait_accept(t, id);
        wait_accept(t, id);
        wait_accept(t, id);
        bus.req_valid = 2'b00;
        watch(ds, rv);
        tick();
        chk("perf_ops", perf_ops, 32'd3);
        chk("perf_busy", perf_busy, 32'd15);
`endif

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpall_sched.md
# fpall_sched

Two-requester issue controller for the shared, non-pipelined fpall arithmetic unit (ADD/MUL/SQRT/DIV on FP32 or packed 2×BF16). It arbitrates round-robin between two requesters and registers the winning operation. It sequences one operation at a time through the datapath using per-op fixed latencies, then returns the result tagged with the requester id under valid/ready backpressure. It sits between the front-end request ports and the fpall datapath instance.

## Interface
- `LAT_ADD`, 2: cycles from `dp_start` to valid `dp_result` for OP_ADD (legal 1..63)
- `LAT_MUL`, 3: same, OP_MUL
- `LAT_SQRT`, 12: same, OP_SQRT
- `LAT_DIV`, 12: same, OP_DIV
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  2  per-requester request valid, bit i = requester i
- `req_ready`  out  2  per-requester accept
- `req0_op`, `req1_op`  in  2 each  fp_op_e
- `req0_fmt`, `req1_fmt`  in  1 each  fp_fmt_e; FP32=0, FP16=1 means packed 2×BF16 lanes (hi/lo)
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  32 each  operands (fp_vec_u)
- `dp_start`  out  1  one-cycle start pulse to datapath
- `dp_op`  out  2  registered op, stable from `dp_start` until capture
- `dp_fmt`  out  1  registered fmt, stable likewise
- `dp_a`, `dp_b`  out  32 each  registered operands, stable likewise
- `dp_result`  in  32  datapath result
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  consumer accept
- `rsp_id`  out  1  requester that issued the op
- `rsp_data`  out  32  result

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - `req_ready[i]` = `req_valid[i]` & grant[i]; at most one bit of `req_ready` is high.
  - Grant: if only one requester is valid, it wins. If both are valid, the one not granted last wins. `last_grant` resets to 1, so requester 0 wins the first tie.
  - On accept: register op/fmt/a/b and id, update `last_grant`, go to ISSUE.
- ISSUE
  - `dp_start`=1 for exactly this cycle.
  - Load down-counter with LAT of the registered op; go to WAIT.
- WAIT
  - Decrement each cycle. When counter==1, capture `dp_result` into `rsp_data` at the clock edge and go to RESP.
- RESP
  - `rsp_valid`=1; `rsp_data`/`rsp_id` held stable until `rsp_valid`&`rsp_ready`, then go to IDLE.
  - `req_ready`=0 in ISSUE, WAIT and RESP (single op in flight, no bypass).
- Datapath outputs hold the last issued values when not busy; no X after reset.
- Counter width is 6 bits. LAT=1 means capture at the edge ending the cycle after ISSUE.
- Reset is legal mid-operation: the in-flight op is discarded and no response is produced.

## Timing
- Reset values: `req_ready`=0, `dp_start`=0, `dp_op`=0, `dp_fmt`=0, `dp_a`=0, `dp_b`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, state=IDLE.
- For an accept at cycle T:
  - `dp_start` is high at T+1.
  - The datapath result must be valid at T+1+LAT.
  - `rsp_valid` rises at T+2+LAT.
- With `rsp_ready` held high, the next accept is possible at T+3+LAT, i.e. throughput is one op per LAT+3 cycles.
- Request signals may change freely while `req_ready` is low; only the accept-cycle values are used.

## Configuration
- `FPALL_SCHED_PERF_EN` defined: adds outputs `perf_ops` (32, increments on each `dp_start`) and `perf_busy` (32, increments every cycle state≠IDLE). Both reset to 0 and wrap modulo 2^32.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

## Structure
- Shared package (fpall_pkg): fp_fmt_e, fp_op_e, fp_vec_u. Add sched_state_e (IDLE/ISSUE/WAIT/RESP) and a function mapping fp_op_e to latency given the four parameters.
- One sub-module, `fpall_rr_arb2`: 2-input round-robin arbiter with `last_grant` register and an update-on-accept input.
- Remaining control is flat in fpall_sched.

## Test plan
- Single ADD from req0 with a=0x3F800000, b=0x40000000, fp32, model returns 0x40400000 at LAT_ADD: `dp_start` at T+1, `rsp_valid` at T+4, `rsp_id`=0, `rsp_data`=0x40400000.
- Both valid every cycle, rsp_ready=1, 4 ops: grants go 0,1,0,1; `rsp_id` sequence 0,1,0,1.
- DIV from req1 with fmt=FP16, a=0x3F804000, b=0x40004000: `dp_fmt`=1 and operands stable for all 12 WAIT cycles; response after 14 cycles.
- `rsp_ready` low for 5 cycles in RESP: `rsp_valid`/`rsp_data` stable, `req_ready`=0 throughout, accept resumes the cycle after handshake.
- `rst_n` asserted during WAIT of a SQRT: all outputs return to reset values immediately; no response after release; next request is serviced normally with requester 0 winning a tie.
- With `FPALL_SCHED_PERF_EN`: 3 MUL ops back-to-back → `perf_ops`=3, `perf_busy`=3×(LAT_MUL+2)=15 given zero RESP stall.
